// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle shared by the round-robin arbiter and its requesters.
// The master side raises requests and freeze; the slave side (the arbiter)
// returns the registered one-hot grant, its binary index and a valid flag.
interface rr_arbiter8_if;
  logic       freeze;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;

  modport master (
    output freeze,
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld
  );

  modport slave (
    input  freeze,
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_vld
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and binary
// index. The search starts at a rotating pointer that moves past each owner
// as it releases or is pre-empted. An owner that has held the grant for
// MAX_HOLD cycles while others wait is pre-empted (MAX_HOLD=0 disables it).
// freeze blocks new grants, handoffs and pre-emption but not releases.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter8_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LIM   = 8'(MAX_HOLD);
  // With pre-emption disabled the counter has no meaningful limit, so it
  // simply saturates at its full range.
  localparam logic [7:0] HOLD_SAT   = PREEMPT_EN ? 8'(MAX_HOLD) : 8'hFF;

  // Returns {found, index} of the first set bit of r visited in the order
  // start, start+1, ..., start+7 (mod 8). Walking downwards lets the lowest
  // offset overwrite the result last, so no early exit is needed.
  function automatic logic [3:0] find_first(input logic [7:0] r,
                                            input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Registered state
  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_idx;
  logic       r_gnt_vld;

  // Next-state values
  state_t     w_state_n;
  logic [2:0] w_ptr_n;
  logic [7:0] w_hold_n;
  logic [7:0] w_gnt_n;
  logic [2:0] w_gnt_idx_n;
  logic       w_gnt_vld_n;

  // Owner-relative decode
  logic [7:0] w_owner_bit;
  logic       w_owner_req;
  logic [7:0] w_others;
  logic [2:0] w_ptr_after;
  logic [3:0] w_cand_idle;
  logic [3:0] w_cand_next;
  logic       w_preempt;

  assign w_owner_bit = 8'(1) << r_gnt_idx;
  assign w_owner_req = |(bus.req & w_owner_bit);
  assign w_others    = bus.req & ~w_owner_bit;
  assign w_ptr_after = r_gnt_idx + 3'd1;

  // From IDLE the search runs over all requests from the stored pointer.
  assign w_cand_idle = find_first(bus.req, r_ptr);
  // On release or pre-emption the owner is excluded and the search restarts
  // just past it; on release req[owner] is already 0, so one search serves both.
  assign w_cand_next = find_first(w_others, w_ptr_after);

  assign w_preempt = PREEMPT_EN && (r_hold_cnt == HOLD_LIM) &&
                     (|w_others) && !bus.freeze;

  // Next-state, pointer, hold counter and grant decode
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    w_state_n   = r_state;
    w_ptr_n     = r_ptr;
    w_hold_n    = r_hold_cnt;
    w_gnt_n     = r_gnt;
    w_gnt_idx_n = r_gnt_idx;
    w_gnt_vld_n = r_gnt_vld;

    unique case (r_state)
      S_IDLE: begin
        if (w_cand_idle[3] && !bus.freeze) begin
          w_gnt_n     = 8'(1) << w_cand_idle[2:0];
          w_gnt_idx_n = w_cand_idle[2:0];
          w_gnt_vld_n = 1'b1;
          w_hold_n    = 8'd1;
          w_state_n   = S_GRANT;
        end
      end

      S_GRANT: begin
        if (!w_owner_req) begin
          // Release: the pointer always moves past the departing owner.
          w_ptr_n = w_ptr_after;
          if (w_cand_next[3] && !bus.freeze) begin
            // Same-edge handoff keeps gnt_vld high with no idle cycle.
            w_gnt_n     = 8'(1) << w_cand_next[2:0];
            w_gnt_idx_n = w_cand_next[2:0];
            w_hold_n    = 8'd1;
          end else begin
            w_gnt_n     = 8'h00;
            w_gnt_idx_n = 3'd0;
            w_gnt_vld_n = 1'b0;
            w_hold_n    = 8'd0;
            w_state_n   = S_IDLE;
          end
        end else if (w_preempt) begin
          w_ptr_n     = w_ptr_after;
          w_gnt_n     = 8'(1) << w_cand_next[2:0];
          w_gnt_idx_n = w_cand_next[2:0];
          w_hold_n    = 8'd1;
        end else if (r_hold_cnt != HOLD_SAT) begin
          // Counts under freeze too, so a stalled pre-emption fires on the
          // first unfrozen edge.
          w_hold_n = r_hold_cnt + 8'd1;
        end
      end

      default: begin
        w_state_n   = S_IDLE;
        w_gnt_n     = 8'h00;
        w_gnt_idx_n = 3'd0;
        w_gnt_vld_n = 1'b0;
        w_hold_n    = 8'd0;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a small control flop, so all are cleared by
    // the asynchronous reset; outputs drop immediately when rst_n falls.
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 3'd0;
      r_hold_cnt <= 8'd0;
      r_gnt      <= 8'h00;
      r_gnt_idx  <= 3'd0;
      r_gnt_vld  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above.
      r_state    <= w_state_n;
      r_ptr      <= w_ptr_n;
      r_hold_cnt <= w_hold_n;
      r_gnt      <= w_gnt_n;
      r_gnt_idx  <= w_gnt_idx_n;
      r_gnt_vld  <= w_gnt_vld_n;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8. Directed steps push the grant expected
// after the next edge into a queue tagged with that edge's cycle number; a
// negedge monitor pops and compares. A random soak then checks invariants
// every cycle and the worst-case wait of persistent requesters.
module tb_rr_arbiter8;

  localparam int WAIT_BOUND = 7 * 4 + 8;

  typedef struct {
    int         cyc;
    bit         sel;   // 0: MAX_HOLD=4 instance, 1: MAX_HOLD=0 instance
    logic [7:0] gnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t e;

  rr_arbiter8_if bus4 ();
  rr_arbiter8_if bus0 ();

  rr_arbiter8 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  rr_arbiter8 #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] enc(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  // Monitor: compare whichever expectations belong to the edge just taken.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        check("sb_late", 32'(e.cyc), 32'(cyc));
      end else if (!e.sel) begin
        check("h4_gnt", 32'(bus4.gnt), 32'(e.gnt));
        check("h4_idx", 32'(bus4.gnt_idx), 32'(enc(e.gnt)));
        check("h4_vld", 32'(bus4.gnt_vld), 32'(|e.gnt));
      end else begin
        check("h0_gnt", 32'(bus0.gnt), 32'(e.gnt));
        check("h0_idx", 32'(bus0.gnt_idx), 32'(enc(e.gnt)));
        check("h0_vld", 32'(bus0.gnt_vld), 32'(|e.gnt));
      end
    end
  end

  // Drive one cycle of inputs at posedge+1 and queue the grant expected
  // after the following edge.
  task automatic drive(input logic [7:0] r, input logic f, input logic [7:0] g);
    bus4.req    = r;
    bus4.freeze = f;
    q.push_back('{cyc: cyc + 1, sel: 1'b0, gnt: g});
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [7:0] r, input logic f, input logic [7:0] g);
    bus0.req    = r;
    bus0.freeze = f;
    q.push_back('{cyc: cyc + 1, sel: 1'b1, gnt: g});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pre_exp [13];
    logic [7:0] r;
    int wait_c   [8];
    int max_wait [8];

    pre_exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02,
                8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
    for (int i = 0; i < 8; i++) begin
      wait_c[i]   = 0;
      max_wait[i] = 0;
    end

    // 1. Reset with all requests high
    rst_n       = 1'b0;
    bus4.req    = 8'hFF;
    bus4.freeze = 1'b0;
    bus0.req    = 8'h00;
    bus0.freeze = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus4.gnt), 32'h00);
    check("rst_idx", 32'(bus4.gnt_idx), 32'h0);
    check("rst_vld", 32'(bus4.gnt_vld), 32'h0);
    check("rst_gnt_h0", 32'(bus0.gnt), 32'h00);
    rst_n = 1'b1;
    drive(8'hFF, 1'b0, 8'h01);
    drive(8'hFF, 1'b0, 8'h01);
    // Asynchronous clear mid-grant, checked before the next edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(bus4.gnt), 32'h00);
    check("arst_idx", 32'(bus4.gnt_idx), 32'h0);
    check("arst_vld", 32'(bus4.gnt_vld), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2. Handoff without a bubble
    drive(8'h22, 1'b0, 8'h02);
    drive(8'h20, 1'b0, 8'h20);
    drive(8'h02, 1'b0, 8'h02);

    // 3. Wrap-around past requester 7
    drive(8'h80, 1'b0, 8'h80);
    drive(8'h81, 1'b0, 8'h80);
    drive(8'h01, 1'b0, 8'h01);
    drive(8'h80, 1'b0, 8'h80);
    drive(8'h82, 1'b0, 8'h80);
    drive(8'h02, 1'b0, 8'h02);
    drive(8'h00, 1'b0, 8'h00);

    // 4. Pre-emption every 4 cycles, then a sole requester keeps the grant
    for (int i = 0; i < 13; i++) drive(8'h03, 1'b0, pre_exp[i]);
    for (int i = 0; i < 23; i++) drive(8'h01, 1'b0, 8'h01);
    drive(8'h00, 1'b0, 8'h00);

    // 5. Freeze: no grant from IDLE, release to IDLE, delayed pre-emption
    drive(8'h10, 1'b1, 8'h00);
    drive(8'h10, 1'b1, 8'h00);
    drive(8'h10, 1'b0, 8'h10);
    drive(8'h40, 1'b1, 8'h00);
    drive(8'h40, 1'b1, 8'h00);
    drive(8'h40, 1'b0, 8'h40);
    for (int i = 0; i < 6; i++) drive(8'h41, 1'b1, 8'h40);
    drive(8'h41, 1'b0, 8'h01);
    drive(8'h00, 1'b0, 8'h00);

    // 4c. MAX_HOLD=0 never pre-empts
    for (int i = 0; i < 12; i++) drive0(8'h03, 1'b0, 8'h01);
    drive0(8'h02, 1'b0, 8'h02);
    drive0(8'h00, 1'b0, 8'h00);

    // 6. Random soak: invariants always; wait bound once freeze stays low
    r = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      check("inv_onehot", 32'($onehot0(bus4.gnt)), 32'd1);
      check("inv_idx", 32'(bus4.gnt_idx), 32'(enc(bus4.gnt)));
      check("inv_vld", 32'(bus4.gnt_vld), 32'(|bus4.gnt));
      if (n >= 5010) begin
        for (int i = 0; i < 8; i++) begin
          if (bus4.req[i] && !bus4.gnt[i]) wait_c[i]++;
          else wait_c[i] = 0;
          if (wait_c[i] > max_wait[i]) max_wait[i] = wait_c[i];
        end
      end
      for (int i = 0; i < 8; i++) if ($urandom_range(15) == 0) r[i] = ~r[i];
      bus4.req    = r;
      bus4.freeze = (n < 5000) ? ($urandom_range(7) == 0) : 1'b0;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("wait_bound_%0d", i), 32'(max_wait[i] <= WAIT_BOUND), 32'd1);

    // Let the monitor drain any outstanding expectations
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    check("sb_drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
